// File: rtl/sdram_app_burst_master.sv
// -----------------------------------------------------------------------------
// sdram_app_burst_master
//
// Front-end that turns single burst commands (address, length, read/write)
// plus a separate write-data stream into requests on the SDRAM controller
// application port.
//
// Write words are buffered in a first-word-fall-through FIFO. A write burst
// is only requested once the FIFO holds at least the full burst, so the
// controller never waits for data in the middle of a burst. Read words from
// the controller are re-registered and forwarded as a stream without
// backpressure.
//
// Ports
//   sdram_clk        sole clock, rising edge
//   reset            synchronous, active-high; aborts any burst, empties FIFO
//   cmd_valid/ready  command handshake (IDLE only)
//   cmd_addr/len     burst start address / length in words (1..2^LEN_W-1)
//   cmd_wr_n         1 = read, 0 = write
//   wdat_valid/ready write-data handshake (ready = FIFO not full)
//   wdat_data/be_n   write word and active-low byte enables
//   rdat_valid       read word valid, one cycle after app_rd_valid
//   rdat_data/last   read word, last word of the burst
//   app_req*         request to controller, held until app_req_ack
//   app_wr_data/en_n FIFO head word / byte enables while in WDATA
//   app_wr_next_req  controller consumes one write word this cycle
//   app_rd_*         read data from controller
//   app_last_rd/wr   controller flags the final word of a burst
//   busy             FSM not in IDLE
//   err_pulse        one-cycle flag: illegal command or FIFO underrun
//
// Handshake semantics: a transfer on cmd_* or wdat_* happens on every rising
// edge where valid and ready are both 1. Ready never depends on valid; valid
// may be raised or dropped at any time without consequence when ready is 0.
// rdat_* has no ready: the consumer must take every word flagged by
// rdat_valid.
// -----------------------------------------------------------------------------
module sdram_app_burst_master #(
  parameter int APP_AW   = 26,
  parameter int APP_DW   = 32,
  parameter int APP_BW   = 4,
  parameter int LEN_W    = 9,
  parameter int WF_DEPTH = 16
) (
  input  logic              sdram_clk,
  input  logic              reset,

  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_wr_n,

  // write-data stream
  input  logic              wdat_valid,
  output logic              wdat_ready,
  input  logic [APP_DW-1:0] wdat_data,
  input  logic [APP_BW-1:0] wdat_be_n,

  // read-data stream
  output logic              rdat_valid,
  output logic [APP_DW-1:0] rdat_data,
  output logic              rdat_last,

  // controller application port
  output logic              app_req,
  output logic [APP_AW-1:0] app_req_addr,
  output logic [LEN_W-1:0]  app_req_len,
  output logic              app_req_wr_n,
  output logic              app_req_wrap,
  input  logic              app_req_ack,
  output logic [APP_DW-1:0] app_wr_data,
  output logic [APP_BW-1:0] app_wr_en_n,
  input  logic              app_wr_next_req,
  input  logic [APP_DW-1:0] app_rd_data,
  input  logic              app_rd_valid,
  input  logic              app_last_rd,
  input  logic              app_last_wr,

  // status
  output logic              busy,
  output logic              err_pulse
);

  localparam int          PTR_W      = $clog2(WF_DEPTH);
  localparam int          CNT_W      = PTR_W + 1;
  localparam logic [31:0] WF_DEPTH_U = WF_DEPTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_REQ     = 3'd2,
    S_WDATA   = 3'd3,
    S_RDATA   = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // latched command
  logic [APP_AW-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              wr_n_q;

  // burst word counter and request/error registers
  logic [LEN_W-1:0]  cnt;
  logic              req_q;
  logic              err_q;

  // read-data output registers
  logic              rdat_valid_q;
  logic [APP_DW-1:0] rdat_data_q;
  logic              rdat_last_q;

  // write-data FIFO
  logic [APP_DW-1:0] mem_data [WF_DEPTH];
  logic [APP_BW-1:0] mem_be_n [WF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              underrun;

  // decoded command / burst conditions
  logic              cmd_hs;
  logic              cmd_bad;
  logic              last_word;
  logic              prefill_done;
  logic              ack_seen;

  assign fifo_empty   = (fifo_count == '0);
  assign fifo_full    = (fifo_count == CNT_W'(WF_DEPTH));
  assign push         = wdat_valid && wdat_ready;

  assign cmd_hs       = cmd_valid && cmd_ready;
  // Zero-length bursts are meaningless; a write longer than the FIFO could
  // never be fully buffered and would deadlock in PREFILL.
  assign cmd_bad      = (cmd_len == '0) ||
                        (!cmd_wr_n && (32'(cmd_len) > WF_DEPTH_U));
  assign last_word    = (cnt == (len_q - LEN_W'(1)));
  assign prefill_done = (32'(fifo_count) >= 32'(len_q));
  // The ack only counts once the request is actually visible on app_req.
  assign ack_seen     = req_q && app_req_ack;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    pop       = 1'b0;
    underrun  = 1'b0;

    case (state)
      S_IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid && !reset && !cmd_bad) begin
          state_nxt = cmd_wr_n ? S_REQ : S_PREFILL;
        end
      end

      S_PREFILL: begin
        if (prefill_done) begin
          state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        if (ack_seen) begin
          state_nxt = wr_n_q ? S_RDATA : S_WDATA;
        end
      end

      S_WDATA: begin
        if (app_wr_next_req) begin
          pop      = !fifo_empty;
          underrun = fifo_empty;
        end
        if (app_last_wr || (app_wr_next_req && last_word)) begin
          state_nxt = S_IDLE;
        end
      end

      S_RDATA: begin
        if (app_rd_valid && (last_word || app_last_rd)) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch, request, counter, read path, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      addr_q       <= '0;
      len_q        <= '0;
      wr_n_q       <= 1'b0;
      cnt          <= '0;
      req_q        <= 1'b0;
      err_q        <= 1'b0;
      rdat_valid_q <= 1'b0;
      rdat_data_q  <= '0;
      rdat_last_q  <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        wr_n_q <= cmd_wr_n;
      end

      err_q <= (cmd_hs && cmd_bad) || underrun;

      // Rises the cycle after REQ is entered, falls the cycle after the ack.
      req_q <= (state == S_REQ) && !ack_seen;

      if (state == S_REQ) begin
        cnt <= '0;
      end else if (((state == S_WDATA) && app_wr_next_req) ||
                   ((state == S_RDATA) && app_rd_valid)) begin
        cnt <= cnt + LEN_W'(1);
      end

      rdat_valid_q <= (state == S_RDATA) && app_rd_valid;
      rdat_last_q  <= (state == S_RDATA) && app_rd_valid &&
                      (last_word || app_last_rd);
      if ((state == S_RDATA) && app_rd_valid) begin
        rdat_data_q <= app_rd_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write-data FIFO: pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: only entries below the occupancy are ever read.
  always_ff @(posedge sdram_clk) begin
    if (push) begin
      mem_data[wr_ptr] <= wdat_data;
      mem_be_n[wr_ptr] <= wdat_be_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wdat_ready   = !fifo_full;

  assign rdat_valid   = rdat_valid_q;
  assign rdat_data    = rdat_data_q;
  assign rdat_last    = rdat_last_q;

  assign app_req      = req_q;
  assign app_req_addr = addr_q;
  assign app_req_len  = len_q;
  assign app_req_wr_n = wr_n_q;
  assign app_req_wrap = 1'b0;

  // FIFO head is presented only during a write burst; elsewhere the bus is
  // parked with all byte lanes disabled.
  assign app_wr_data  = ((state == S_WDATA) && !fifo_empty) ? mem_data[rd_ptr] : '0;
  assign app_wr_en_n  = ((state == S_WDATA) && !fifo_empty) ? mem_be_n[rd_ptr] : '1;

  assign busy         = (state != S_IDLE);
  assign err_pulse    = err_q;

endmodule
